// File: rtl/countdown_display_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : countdown_display_ctrl_pkg
// Brief   : Shared types and constants for the phase countdown display.
// Revision: 1.0 - initial release
// ============================================================================
package countdown_display_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [6:0] MAX_COUNT    = 7'd99;
  localparam logic [1:0] DIG_SEL_ONES = 2'b10;
  localparam logic [1:0] DIG_SEL_TENS = 2'b01;
  localparam logic [1:0] DIG_SEL_OFF  = 2'b11;

  // Inputs are limited to 0..99, so both digits fit in 4 bits.
  function automatic logic [3:0] bcd_ones(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

  function automatic logic [3:0] bcd_tens(input logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_display_ctrl_tick_divider.sv
`default_nettype none
// ============================================================================
// Module  : tick_divider
// Brief   : Enable-gated modulo-DIV counter; tick marks the wrap cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign tick = enable && !clear && (r_cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/countdown_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : countdown_display_ctrl
// Brief   : Two-digit phase countdown with multiplexed seven-segment digit scan.
// Revision: 1.0 - initial release
// ============================================================================
module countdown_display_ctrl
  import countdown_display_ctrl_pkg::*;
#(
  parameter int SEC_DIV  = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [6:0] load_value,
  input  logic       start,
  input  logic       pause,
  output logic [6:0] count,
  output logic       busy,
  output logic       done,
  output logic [3:0] digit_number,
  output logic [1:0] digit_sel
);

  state_t     r_state;
  logic [6:0] r_count;
  logic       r_busy;
  logic       r_done;
  logic       r_scan_tens;
  logic [3:0] r_digit_number;
  logic [1:0] r_digit_sel;

  logic       w_sec_tick;
  logic       w_sec_en;
  logic       w_sec_clear;
  logic       w_scan_tick;
  logic [6:0] w_load_sat;
  logic [3:0] w_ones;
  logic [3:0] w_tens;

  assign w_sec_en    = (r_state == ST_RUN);
  // Prescaler holds through PAUSED so a resumed partial second is kept.
  assign w_sec_clear = load || (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_load_sat  = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
  assign w_ones      = bcd_ones(r_count);
  assign w_tens      = bcd_tens(r_count);

  tick_divider #(.DIV(SEC_DIV)) u_sec_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (w_sec_en),
    .clear  (w_sec_clear),
    .tick   (w_sec_tick)
  );

  tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (1'b1),
    .clear  (1'b0),
    .tick   (w_scan_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (load) begin
      r_state <= ST_IDLE;
      r_count <= w_load_sat;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && (r_count != 7'd0)) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_sec_tick && (r_count == 7'd1)) begin
            r_count <= 7'd0;
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            if (w_sec_tick && (r_count != 7'd0)) begin
              r_count <= r_count - 7'd1;
            end
            if (pause) begin
              r_state <= ST_PAUSED;
            end
          end
        end
        ST_PAUSED: begin
          if (pause) begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Digit value and enable update on the same edge to avoid ghosting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scan_tens    <= 1'b0;
      r_digit_number <= 4'd0;
      r_digit_sel    <= DIG_SEL_ONES;
    end else begin
      if (w_scan_tick) begin
        r_scan_tens <= ~r_scan_tens;
      end
      if (!r_scan_tens) begin
        r_digit_number <= w_ones;
        r_digit_sel    <= DIG_SEL_ONES;
      end else if (w_tens == 4'd0) begin
        r_digit_number <= 4'd0;
        r_digit_sel    <= DIG_SEL_OFF;
      end else begin
        r_digit_number <= w_tens;
        r_digit_sel    <= DIG_SEL_TENS;
      end
    end
  end

  assign count        = r_count;
  assign busy         = r_busy;
  assign done         = r_done;
  assign digit_number = r_digit_number;
  assign digit_sel    = r_digit_sel;

endmodule
`default_nettype wire

// File: tb/tb_countdown_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_countdown_display_ctrl
// Brief   : Scoreboard bench for countdown_display_ctrl (SEC_DIV=4, SCAN_DIV=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_countdown_display_ctrl;

  localparam int K_COUNT = 0;
  localparam int K_BUSY  = 1;
  localparam int K_DONE  = 2;
  localparam int K_SEL   = 3;
  localparam int K_NUM   = 4;

  typedef struct {
    int cyc;
    int kind;
    int val;
    int id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [6:0] load_value;
  logic       start;
  logic       pause;
  logic [6:0] count;
  logic       busy;
  logic       done;
  logic [3:0] digit_number;
  logic [1:0] digit_sel;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_total = 0;
  int   n_pass  = 0;
  int   next_id = 0;
  int   rel_cyc = 0;

  countdown_display_ctrl #(.SEC_DIV(4), .SCAN_DIV(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .load_value   (load_value),
    .start        (start),
    .pause        (pause),
    .count        (count),
    .busy         (busy),
    .done         (done),
    .digit_number (digit_number),
    .digit_sel    (digit_sel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(int k);
    case (k)
      K_COUNT: return int'(count);
      K_BUSY:  return int'(busy);
      K_DONE:  return int'(done);
      K_SEL:   return int'(digit_sel);
      K_NUM:   return int'(digit_number);
      default: return -1;
    endcase
  endfunction

  function automatic string kname(int k);
    case (k)
      K_COUNT: return "count";
      K_BUSY:  return "busy";
      K_DONE:  return "done";
      K_SEL:   return "digit_sel";
      K_NUM:   return "digit_number";
      default: return "unknown";
    endcase
  endfunction

  task automatic expect_at(int target, int kind, int val);
    exp_t e;
    e.cyc  = target;
    e.kind = kind;
    e.val  = val;
    e.id   = next_id;
    next_id++;
    sb.push_back(e);
  endtask

  // Scan slot is fixed by the time since reset release: two cycles ones, two tens.
  task automatic expect_disp(int target, int c);
    int ph;
    ph = (target - rel_cyc - 1) % 4;
    if (ph >= 2) begin
      if (c / 10 == 0) begin
        expect_at(target, K_SEL, 3);
        expect_at(target, K_NUM, 0);
      end else begin
        expect_at(target, K_SEL, 1);
        expect_at(target, K_NUM, c / 10);
      end
    end else begin
      expect_at(target, K_SEL, 2);
      expect_at(target, K_NUM, c % 10);
    end
  endtask

  task automatic nx(int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_total++;
        if (sb[i].cyc == cyc && actual(sb[i].kind) == sb[i].val) begin
          n_pass++;
        end else begin
          $display("FAIL chk%0d %s at cycle %0d: got %0d, expected %0d",
                   sb[i].id, kname(sb[i].kind), sb[i].cyc, actual(sb[i].kind), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    int b;
    rst_n = 1'b0; load = 1'b0; load_value = 7'd0; start = 1'b0; pause = 1'b0;
    nx(1);
    b = cyc;
    expect_at(b + 2, K_COUNT, 0);
    expect_at(b + 2, K_BUSY, 0);
    expect_at(b + 2, K_DONE, 0);
    expect_at(b + 2, K_SEL, 2);
    expect_at(b + 2, K_NUM, 0);
    nx(2);
    rst_n   = 1'b1;
    rel_cyc = cyc;

    // Load 12 and watch the scan alternate
    b = cyc;
    expect_at(b + 1, K_COUNT, 12);
    expect_at(b + 1, K_BUSY, 0);
    for (int d = 2; d < 10; d++) expect_disp(b + d, 12);
    load = 1'b1; load_value = 7'd12;
    nx(1); load = 1'b0;
    nx(9);

    // Load 3, start, count down to done
    b = cyc;
    expect_at(b + 2, K_BUSY, 1);
    expect_at(b + 2, K_COUNT, 3);
    expect_at(b + 5, K_COUNT, 3);
    expect_at(b + 6, K_COUNT, 2);
    expect_at(b + 10, K_COUNT, 1);
    expect_at(b + 13, K_BUSY, 1);
    expect_at(b + 13, K_DONE, 0);
    expect_at(b + 14, K_COUNT, 0);
    expect_at(b + 14, K_DONE, 1);
    expect_at(b + 14, K_BUSY, 0);
    expect_at(b + 15, K_DONE, 0);
    expect_at(b + 15, K_BUSY, 0);
    expect_at(b + 15, K_COUNT, 0);
    load = 1'b1; load_value = 7'd3;
    nx(1); load = 1'b0; start = 1'b1;
    nx(1); start = 1'b0;
    nx(14);

    // Pause holds count and the partial second
    b = cyc;
    expect_at(b + 4, K_COUNT, 5);
    expect_at(b + 10, K_COUNT, 5);
    expect_at(b + 10, K_BUSY, 1);
    expect_at(b + 16, K_COUNT, 5);
    expect_at(b + 17, K_COUNT, 4);
    expect_at(b + 17, K_BUSY, 1);
    load = 1'b1; load_value = 7'd5;
    nx(1); load = 1'b0; start = 1'b1;
    nx(1); start = 1'b0;
    nx(1); pause = 1'b1;
    nx(1); pause = 1'b0;
    nx(10); pause = 1'b1;
    nx(1); pause = 1'b0;
    nx(3);

    // Saturating load, then leading-zero blanking
    b = cyc;
    expect_at(b + 1, K_COUNT, 99);
    expect_at(b + 2, K_COUNT, 7);
    expect_disp(b + 2, 99);
    for (int d = 3; d < 7; d++) expect_disp(b + d, 7);
    load = 1'b1; load_value = 7'd120;
    nx(1); load_value = 7'd7;
    nx(1); load = 1'b0;
    nx(5);

    // Load beats start and pause in the same cycle; start with zero ignored
    b = cyc;
    expect_at(b + 3, K_COUNT, 4);
    expect_at(b + 3, K_BUSY, 1);
    expect_at(b + 4, K_COUNT, 9);
    expect_at(b + 4, K_BUSY, 0);
    expect_at(b + 4, K_DONE, 0);
    expect_at(b + 5, K_DONE, 0);
    expect_at(b + 7, K_COUNT, 9);
    expect_at(b + 9, K_COUNT, 0);
    expect_at(b + 10, K_BUSY, 0);
    expect_at(b + 11, K_BUSY, 0);
    expect_at(b + 11, K_DONE, 0);
    load = 1'b1; load_value = 7'd4;
    nx(1); load = 1'b0; start = 1'b1;
    nx(1); start = 1'b0;
    nx(1); load = 1'b1; load_value = 7'd9; start = 1'b1; pause = 1'b1;
    nx(1); load = 1'b0; start = 1'b0; pause = 1'b0;
    nx(4); load = 1'b1; load_value = 7'd0;
    nx(1); load = 1'b0; start = 1'b1;
    nx(1); start = 1'b0;
    nx(2);

    // Reset in the middle of a countdown
    b = cyc;
    expect_at(b + 4, K_COUNT, 8);
    expect_at(b + 4, K_BUSY, 1);
    expect_at(b + 5, K_COUNT, 0);
    expect_at(b + 5, K_SEL, 2);
    expect_at(b + 5, K_NUM, 0);
    expect_at(b + 5, K_DONE, 0);
    expect_at(b + 5, K_BUSY, 0);
    expect_at(b + 6, K_DONE, 0);
    load = 1'b1; load_value = 7'd8;
    nx(1); load = 1'b0; start = 1'b1;
    nx(1); start = 1'b0;
    nx(2); rst_n = 1'b0;
    nx(1); rst_n = 1'b1;
    nx(2);

    for (int i = 0; i < 50 && sb.size() > 0; i++) nx(1);
    if (sb.size() > 0) begin
      $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
      n_total += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
